reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised power-on/reset sequencer that replaces the ad-hoc 7-bit reset stretch counter in the chip top level. It holds a configurable number of reset domains in reset for a minimum stretch time. It then waits for a debounced PLL lock and releases the domains one at a time in index order. Loss of lock or a software/host reset request re-asserts every domain. It sits between the PLL and the SoC/TestHarness instances in the chip top level.

## Interface
Parameters:
- NUM_RST, 4: number of reset outputs; legal ≥1
- STRETCH, 127: minimum cycles all outputs stay asserted; legal ≥1
- DEBOUNCE, 8: consecutive synchronised-lock-high cycles required; legal ≥1
- STAGE_GAP, 16: cycles between successive releases; legal ≥1

Ports:
- clock  in  1  single clock (PLL output); all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- pll_lock  in  1  PLL lock, asynchronous to clock
- rst_req  in  1  synchronous reset request, active-high, level
- rst_out  out  NUM_RST  per-domain reset, active-high, registered
- ready  out  1  high when all domains released (state RUN)
- lock_loss_cnt  out  8  saturating count of lock losses seen in RELEASE/RUN

## Operation
- Reset values:
  - rst_out = all ones, ready = 0, lock_loss_cnt = 0, state = ASSERT
  - stretch counter = 0, lock filter = 0, synchroniser flops = 0
- pll_lock passes through a 2-flop synchroniser, giving lock_s.
- Lock filter: saturating counter.
  - Increments when lock_s = 1; clears when lock_s = 0.
  - lock_ok = (filter == DEBOUNCE).
- States:
  - ASSERT: rst_out all 1. The counter counts 0..STRETCH-1. rst_req = 1 restarts the counter at 0. Exit to WAIT_LOCK at the edge after the counter reaches STRETCH-1.
  - WAIT_LOCK: rst_out all 1. rst_req = 1 returns to ASSERT with the counter at 0. When lock_ok = 1, go to RELEASE and clear rst_out[0] at that same edge.
  - RELEASE: clear rst_out[k] every STAGE_GAP cycles, in increasing k. Clearing the last index enters RUN and sets ready = 1 at that same edge.
  - RUN: rst_out all 0, ready = 1.
- Abort from RELEASE or RUN, when lock_s = 0 or rst_req = 1:
  - Next edge: state = ASSERT, rst_out all 1, ready = 0, counter = 0.
  - lock_loss_cnt increments (saturating at 255) only when lock_s = 0 caused the abort. If lock_s = 0 and rst_req = 1 occur together, it increments by one.
- lock_s = 0 in ASSERT or WAIT_LOCK only clears the filter. No counter change.
- NUM_RST = 1: WAIT_LOCK goes directly to RUN, with rst_out[0] = 0 and ready = 1 at the same edge.
- Width rules:
  - Counter widths are $clog2(max+1) of STRETCH, DEBOUNCE and STAGE_GAP.
  - The stage index width is $clog2(NUM_RST), with a minimum of 1.
  - No wrap: every counter saturates or is reset by the FSM.

## Timing
- Let edge 0 be the first rising edge with reset = 0, and pll_lock be high throughout.
- rst_out[0] falls at edge STRETCH+1, provided DEBOUNCE+2 ≤ STRETCH.
- rst_out[i] falls at edge STRETCH+1+i·STAGE_GAP.
- ready rises with the last release.
- Defaults: falls at edges 128, 144, 160, 176; ready rises at 176.
- rst_req sampled high at edge n gives outputs asserted after edge n (1-cycle latency).
- pll_lock low at edge n gives lock_s low after edge n+1, and rst_out asserted after edge n+2.
- The lock-loss path has 3-edge worst case.
- After any abort, the full sequence repeats from ASSERT with the counter at 0.
- reset asserted mid-sequence:
  - Applies reset values at that edge, including clearing lock_loss_cnt.
  - No partial state survives.

## Structure
- Package reset_seq_pkg holds:
  - state typedef enum {ASSERT, WAIT_LOCK, RELEASE, RUN}
  - LOSS_CNT_W = 8
- Sub-module sync_2ff (1-bit two-flop synchroniser with synchronous reset to 0), instantiated for pll_lock.
- Everything else lives in reset_sequencer.
- The chip top level instantiates reset_sequencer in place of the inline reset counter, feeding rst_out[0] to the SoC.

## Test plan
- Defaults, lock high from edge 0 → rst_out bits fall at edges 128/144/160/176; ready = 1 at 176; lock_loss_cnt = 0.
- Lock rises only at edge 300 → outputs held until WAIT_LOCK sees lock_ok; rst_out[0] falls at edge 300+2+8+1 = 311 (±1 per the sync/filter rule), then gaps of 16.
- In RUN, drop pll_lock for 1 cycle at edge 500 → all rst_out = 1 by edge 502, ready = 0, lock_loss_cnt = 1, full sequence replays.
- rst_req pulse during RELEASE after rst_out[1] has fallen → all outputs high next edge; lock_loss_cnt unchanged; sequence restarts with a 127-cycle stretch.
- 300 lock-loss events in RUN → lock_loss_cnt saturates at 255; a reset pulse returns it to 0 and rst_out to all ones at that edge.
- NUM_RST=1, STRETCH=4, DEBOUNCE=1, STAGE_GAP=1 → rst_out[0] and ready switch together at edge 5.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// reset_seq_pkg
// Shared types and constants for the reset sequencer.
//   state_t    : sequencer FSM states
//   LOSS_CNT_W : width of the saturating lock-loss counter
// ---------------------------------------------------------------------------
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT,
    WAIT_LOCK,
    RELEASE,
    RUN
  } state_t;

  localparam int unsigned LOSS_CNT_W = 8;

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Single-bit two-flop synchroniser with synchronous active-high reset to 0.
//   i_clk : destination clock
//   i_rst : synchronous reset, active-high
//   i_d   : asynchronous input
//   o_q   : synchronised output (two destination-clock edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Holds NUM_RST reset domains asserted for a minimum stretch, waits for a
// debounced PLL lock, then releases the domains one at a time in index
// order. Lock loss or a reset request during RELEASE/RUN re-asserts all.
//   clock         : PLL output clock, rising edge
//   reset         : synchronous reset, active-high
//   pll_lock      : PLL lock, asynchronous to clock
//   rst_req       : synchronous reset request, active-high level
//   rst_out       : per-domain reset, active-high, registered
//   ready         : high once every domain is released
//   lock_loss_cnt : saturating count of lock losses seen in RELEASE/RUN
// ---------------------------------------------------------------------------
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_RST   = 4,
  parameter int unsigned STRETCH   = 127,
  parameter int unsigned DEBOUNCE  = 8,
  parameter int unsigned STAGE_GAP = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pll_lock,
  input  logic                  rst_req,
  output logic [NUM_RST-1:0]    rst_out,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int unsigned CNT_W = $clog2(STRETCH + 1);
  localparam int unsigned FLT_W = $clog2(DEBOUNCE + 1);
  localparam int unsigned GAP_W = $clog2(STAGE_GAP + 1);
  localparam int unsigned IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  localparam logic [CNT_W-1:0] STRETCH_C  = CNT_W'(STRETCH);
  localparam logic [FLT_W-1:0] DEBOUNCE_C = FLT_W'(DEBOUNCE);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_RST - 1);
  localparam logic [IDX_W-1:0] IDX_SECOND = IDX_W'(1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [FLT_W-1:0]        r_filt;
  logic [GAP_W-1:0]        r_gap;
  logic [IDX_W-1:0]        r_idx;
  logic [NUM_RST-1:0]      r_rst_out;
  logic                    r_ready;
  logic [LOSS_CNT_W-1:0]   r_loss;

  logic                    w_lock_s;
  logic                    w_lock_ok;
  logic                    w_stretch_done;
  logic                    w_stage_tick;
  logic                    w_abort;
  logic [NUM_RST-1:0]      w_rst_nxt;
  logic                    w_ready_nxt;

  sync_2ff u_lock_sync (
    .i_clk (clock),
    .i_rst (reset),
    .i_d   (pll_lock),
    .o_q   (w_lock_s)
  );

  // Counter starts at 0 on ASSERT entry and exits once it has sampled
  // STRETCH, so rst_out[0] can first fall STRETCH+1 edges after entry.
  assign w_stretch_done = (r_cnt == STRETCH_C);
  assign w_lock_ok      = (r_filt == DEBOUNCE_C);
  assign w_stage_tick   = (r_state == RELEASE) && (r_gap == GAP_LAST);
  assign w_abort        = ((r_state == RELEASE) || (r_state == RUN)) &&
                          (!w_lock_s || rst_req);

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= ASSERT;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ASSERT: begin
        if (!rst_req && w_stretch_done) w_state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (rst_req)        w_state_nxt = ASSERT;
        else if (w_lock_ok) w_state_nxt = (NUM_RST == 1) ? RUN : RELEASE;
      end
      RELEASE: begin
        if (w_abort)                                 w_state_nxt = ASSERT;
        else if (w_stage_tick && (r_idx == IDX_LAST)) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_abort) w_state_nxt = ASSERT;
      end
      default: w_state_nxt = ASSERT;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_rst_nxt   = r_rst_out;
    w_ready_nxt = 1'b0;
    if ((w_state_nxt == ASSERT) || (w_state_nxt == WAIT_LOCK)) begin
      w_rst_nxt = '1;
    end else if (w_state_nxt == RUN) begin
      w_rst_nxt   = '0;
      w_ready_nxt = 1'b1;
    end else if (r_state == WAIT_LOCK) begin
      w_rst_nxt    = '1;
      w_rst_nxt[0] = 1'b0;
    end else if (w_stage_tick) begin
      w_rst_nxt[r_idx] = 1'b0;
    end
  end

  // Counters, filter and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_filt    <= '0;
      r_gap     <= '0;
      r_idx     <= '0;
      r_loss    <= '0;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
    end else begin
      if (!w_lock_s)      r_filt <= '0;
      else if (!w_lock_ok) r_filt <= r_filt + 1'b1;

      if ((r_state == ASSERT) && !rst_req && !w_stretch_done) r_cnt <= r_cnt + 1'b1;
      else                                                     r_cnt <= '0;

      if ((r_state == RELEASE) && !w_abort && !w_stage_tick) r_gap <= r_gap + 1'b1;
      else                                                    r_gap <= '0;

      // r_idx names the next domain to release; bit 0 goes on RELEASE entry
      if (w_state_nxt == RELEASE) begin
        if (r_state == WAIT_LOCK) r_idx <= IDX_SECOND;
        else if (w_stage_tick)    r_idx <= r_idx + 1'b1;
      end else begin
        r_idx <= '0;
      end

      if (w_abort && !w_lock_s && (r_loss != '1)) r_loss <= r_loss + 1'b1;

      r_rst_out <= w_rst_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign rst_out       = r_rst_out;
  assign ready         = r_ready;
  assign lock_loss_cnt = r_loss;

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
// Scoreboard bench for reset_sequencer. Instance 0 uses default parameters,
// instance 1 uses NUM_RST=1, STRETCH=4, DEBOUNCE=1, STAGE_GAP=1. Stimulus
// pushes the expected output change (edge number and values) into a queue
// per instance; a monitor pops and compares on every output change.
// Edge numbers count rising clock edges from the start of simulation.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = -1;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a  = 1'b1;
  logic       lock_a = 1'b1;
  logic       req_a  = 1'b0;
  logic [3:0] rout_a;
  logic       rdy_a;
  logic [7:0] loss_a;

  logic       rst_b  = 1'b1;
  logic       lock_b = 1'b1;
  logic       req_b  = 1'b0;
  logic [0:0] rout_b;
  logic       rdy_b;
  logic [7:0] loss_b;

  reset_sequencer u_a (
    .clock         (clk),
    .reset         (rst_a),
    .pll_lock      (lock_a),
    .rst_req       (req_a),
    .rst_out       (rout_a),
    .ready         (rdy_a),
    .lock_loss_cnt (loss_a)
  );

  reset_sequencer #(
    .NUM_RST   (1),
    .STRETCH   (4),
    .DEBOUNCE  (1),
    .STAGE_GAP (1)
  ) u_b (
    .clock         (clk),
    .reset         (rst_b),
    .pll_lock      (lock_b),
    .rst_req       (req_b),
    .rst_out       (rout_b),
    .ready         (rdy_b),
    .lock_loss_cnt (loss_b)
  );

  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic       rdy;
    logic [7:0] loss;
  } exp_t;

  exp_t q_exp[2][$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic push(input int inst, input int c, input logic [3:0] r,
                      input logic rd, input logic [7:0] l);
    exp_t e;
    e.cyc  = c;
    e.rst  = r;
    e.rdy  = rd;
    e.loss = l;
    q_exp[inst].push_back(e);
  endtask

  // Return just after edge n-1, so values driven now are sampled at edge n.
  task automatic goto(input int n);
    while (cyc < n - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every change of {rst_out, ready, lock_loss_cnt} is a DUT event.
  logic [12:0] prev [2];
  bit          have_prev [2] = '{1'b0, 1'b0};
  logic [12:0] cur;
  exp_t        ev;

  always @(negedge clk) begin
    if (cyc >= 0) begin
      for (int i = 0; i < 2; i++) begin
        cur = (i == 0) ? {rout_a, rdy_a, loss_a} : {3'b000, rout_b, rdy_b, loss_b};
        if (!have_prev[i] || (cur !== prev[i])) begin
          n_checks++;
          if (q_exp[i].size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_inst%0d: edge %0d got rst_out=%h ready=%b loss=%0d, required no change",
                     i, cyc, cur[12:9], cur[8], cur[7:0]);
          end else begin
            ev = q_exp[i].pop_front();
            if ((ev.cyc != cyc) || (cur !== {ev.rst, ev.rdy, ev.loss})) begin
              n_errors++;
              $display("FAIL evt_inst%0d: got edge %0d rst_out=%h ready=%b loss=%0d, required edge %0d rst_out=%h ready=%b loss=%0d",
                       i, cyc, cur[12:9], cur[8], cur[7:0], ev.cyc, ev.rst, ev.rdy, ev.loss);
            end
          end
        end
        prev[i]      = cur;
        have_prev[i] = 1'b1;
      end
    end
  end

  task automatic stim_a();
    push(0, 0, 4'hF, 1'b0, 8'd0);                 // reset values
    goto(5); rst_a = 1'b0;                        // edge 5 = first edge out of reset
    push(0, 133, 4'hE, 1'b0, 8'd0);
    push(0, 149, 4'hC, 1'b0, 8'd0);
    push(0, 165, 4'h8, 1'b0, 8'd0);
    push(0, 181, 4'h0, 1'b1, 8'd0);
    // one-cycle lock drop in RUN: abort two edges later
    goto(505); lock_a = 1'b0;
    push(0, 507, 4'hF, 1'b0, 8'd1);
    goto(506); lock_a = 1'b1;
    push(0, 636, 4'hE, 1'b0, 8'd1);
    push(0, 652, 4'hC, 1'b0, 8'd1);
    // request during RELEASE after rst_out[1] fell
    goto(655); req_a = 1'b1;
    push(0, 655, 4'hF, 1'b0, 8'd1);
    goto(656); req_a = 1'b0;
    // request in ASSERT restarts the stretch without output change
    goto(705); req_a = 1'b1;
    goto(706); req_a = 1'b0;
    push(0, 834, 4'hE, 1'b0, 8'd1);
    push(0, 850, 4'hC, 1'b0, 8'd1);
    push(0, 866, 4'h8, 1'b0, 8'd1);
    push(0, 882, 4'h0, 1'b1, 8'd1);
    // lock loss coinciding with request counts once; low lock in ASSERT ignored
    goto(905); lock_a = 1'b0;
    goto(907); req_a = 1'b1;
    push(0, 907, 4'hF, 1'b0, 8'd2);
    goto(908); req_a = 1'b0;
    goto(955); lock_a = 1'b1;
    push(0, 1036, 4'hE, 1'b0, 8'd2);
    push(0, 1052, 4'hC, 1'b0, 8'd2);
    push(0, 1068, 4'h8, 1'b0, 8'd2);
    push(0, 1084, 4'h0, 1'b1, 8'd2);
    // mid-sequence reset, then late lock with a request while in WAIT_LOCK
    goto(1100); rst_a = 1'b1; lock_a = 1'b0;
    push(0, 1100, 4'hF, 1'b0, 8'd0);
    goto(1105); rst_a = 1'b0;
    goto(1300); req_a = 1'b1;
    goto(1301); req_a = 1'b0;
    goto(1406); lock_a = 1'b1;
    push(0, 1429, 4'hE, 1'b0, 8'd0);
    push(0, 1445, 4'hC, 1'b0, 8'd0);
    push(0, 1461, 4'h8, 1'b0, 8'd0);
    push(0, 1477, 4'h0, 1'b1, 8'd0);
    goto(1500);
  endtask

  task automatic stim_b();
    push(1, 0, 4'h1, 1'b0, 8'd0);
    goto(5); rst_b = 1'b0;
    push(1, 10, 4'h0, 1'b1, 8'd0);                // rst_out[0] and ready together
    for (int k = 1; k <= 300; k++) begin
      int d;
      int l;
      d = 20 + 10 * (k - 1);
      l = (k > 255) ? 255 : k;
      goto(d); lock_b = 1'b0;
      push(1, d + 2, 4'h1, 1'b0, 8'(l));
      push(1, d + 8, 4'h0, 1'b1, 8'(l));
      goto(d + 1); lock_b = 1'b1;
    end
    goto(3030); rst_b = 1'b1;
    push(1, 3030, 4'h1, 1'b0, 8'd0);
    goto(3031); rst_b = 1'b0;
    push(1, 3036, 4'h0, 1'b1, 8'd0);
    goto(3050);
  endtask

  initial begin
    fork
      stim_a();
      stim_b();
    join
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      while (q_exp[i].size() > 0) begin
        exp_t m;
        m = q_exp[i].pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL missing_inst%0d: got no change, required edge %0d rst_out=%h ready=%b loss=%0d",
                 i, m.cyc, m.rst, m.rdy, m.loss);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: got time limit at edge %0d, required end of stimulus", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
